// File: rtl/robot_monitor.sv
// robot_monitor
//   Watches a stream of robot position samples (row, column, orientation) and
//   flags three faults: leaving the map, moving more than one cell (or, when
//   STRICT_HEADING is set, moving against the new heading), and sitting
//   completely still for STALL_LIMIT samples. The first fault latches
//   error_code and parks the monitor in HALT until clear or reset.
//
//   Ports
//     clock              system clock, rising edge
//     reset              asynchronous, active-high reset
//     sample             strobe, robot_* inputs valid this cycle
//     robot_row          robot row (map rows 1..ROWS)
//     robot_column       robot column (map columns 1..COLS)
//     robot_orientation  00 north, 01 south, 10 east, 11 west
//     clear              synchronous clear, wins over sample
//     out_of_map         sticky flag
//     illegal_move       sticky flag
//     stall              sticky flag
//     error_code         first error: 00 none, 01 map, 10 move, 11 stall
//     step_count         samples that changed cell, saturating
//     halted             high while in HALT
//
//   state  | meaning
//   IDLE   | no reference sample yet; next sample becomes the reference
//   TRACK  | reference held; each sample is checked and becomes the new one
//   HALT   | an error was seen; samples ignored, outputs frozen

module robot_monitor #(
    parameter int ROWS           = 10,
    parameter int COLS           = 20,
    parameter int POS_W          = 6,
    parameter int STALL_LIMIT    = 16,
    parameter int CNT_W          = 16,
    parameter int STRICT_HEADING = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample,
    input  logic [POS_W-1:0] robot_row,
    input  logic [POS_W-1:0] robot_column,
    input  logic [1:0]       robot_orientation,
    input  logic             clear,
    output logic             out_of_map,
    output logic             illegal_move,
    output logic             stall,
    output logic [1:0]       error_code,
    output logic [CNT_W-1:0] step_count,
    output logic             halted
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    localparam logic [POS_W-1:0]        ROW_MAX   = POS_W'(ROWS);
    localparam logic [POS_W-1:0]        COL_MAX   = POS_W'(COLS);
    localparam logic [SC_W-1:0]         STALL_MAX = SC_W'(STALL_LIMIT);
    localparam logic signed [POS_W:0]   D_POS     = (POS_W+1)'(1);
    localparam logic signed [POS_W:0]   D_NEG     = -D_POS;
    localparam logic signed [POS_W:0]   D_ZERO    = '0;

    localparam logic [1:0] ORI_N = 2'b00;
    localparam logic [1:0] ORI_S = 2'b01;
    localparam logic [1:0] ORI_E = 2'b10;
    localparam logic [1:0] ORI_W = 2'b11;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_MAP   = 2'b01;
    localparam logic [1:0] EC_MOVE  = 2'b10;
    localparam logic [1:0] EC_STALL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TRACK = 2'b01,
        S_HALT  = 2'b10
    } state_t;

    state_t             state, state_nxt;
    logic [POS_W-1:0]   ref_row, ref_row_nxt;
    logic [POS_W-1:0]   ref_col, ref_col_nxt;
    logic [1:0]         ref_ori, ref_ori_nxt;
    logic [SC_W-1:0]    stall_cnt, stall_cnt_nxt;
    logic               out_of_map_nxt, illegal_move_nxt, stall_nxt;
    logic [1:0]         error_code_nxt;
    logic [CNT_W-1:0]   step_count_nxt;

    logic signed [POS_W:0] d_row, d_col;
    logic                  oom, same_cell, same_all, move_one, heading_ok, legal;
    logic                  stall_hit;
    logic [SC_W-1:0]       stall_inc;

    // Deltas are taken one bit wider and signed so that a step back toward
    // row/column 0 produces -1 instead of wrapping.
    assign d_row = $signed({1'b0, robot_row})    - $signed({1'b0, ref_row});
    assign d_col = $signed({1'b0, robot_column}) - $signed({1'b0, ref_col});

    assign oom = (robot_row == '0) || (robot_row > ROW_MAX) ||
                 (robot_column == '0) || (robot_column > COL_MAX);

    assign same_cell = (d_row == D_ZERO) && (d_col == D_ZERO);
    assign same_all  = same_cell && (robot_orientation == ref_ori);
    assign move_one  = ((d_row == D_ZERO) && ((d_col == D_POS) || (d_col == D_NEG))) ||
                       ((d_col == D_ZERO) && ((d_row == D_POS) || (d_row == D_NEG)));

    always_comb begin
        heading_ok = 1'b0;
        case (robot_orientation)
            ORI_N:   heading_ok = (d_row == D_NEG);
            ORI_S:   heading_ok = (d_row == D_POS);
            ORI_E:   heading_ok = (d_col == D_POS);
            ORI_W:   heading_ok = (d_col == D_NEG);
            default: heading_ok = 1'b0;
        endcase
    end

    assign legal = same_cell || (move_one && ((STRICT_HEADING == 0) || heading_ok));

    // The monitor halts as soon as the limit is hit, so the counter never
    // needs to go past STALL_LIMIT.
    assign stall_inc = stall_cnt + 1'b1;
    assign stall_hit = !oom && same_all && (stall_inc >= STALL_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            ref_row      <= '0;
            ref_col      <= '0;
            ref_ori      <= '0;
            stall_cnt    <= '0;
            out_of_map   <= 1'b0;
            illegal_move <= 1'b0;
            stall        <= 1'b0;
            error_code   <= EC_NONE;
            step_count   <= '0;
        end else begin
            state        <= state_nxt;
            ref_row      <= ref_row_nxt;
            ref_col      <= ref_col_nxt;
            ref_ori      <= ref_ori_nxt;
            stall_cnt    <= stall_cnt_nxt;
            out_of_map   <= out_of_map_nxt;
            illegal_move <= illegal_move_nxt;
            stall        <= stall_nxt;
            error_code   <= error_code_nxt;
            step_count   <= step_count_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        ref_row_nxt      = ref_row;
        ref_col_nxt      = ref_col;
        ref_ori_nxt      = ref_ori;
        stall_cnt_nxt    = stall_cnt;
        out_of_map_nxt   = out_of_map;
        illegal_move_nxt = illegal_move;
        stall_nxt        = stall;
        error_code_nxt   = error_code;
        step_count_nxt   = step_count;

        if (clear) begin
            state_nxt        = S_IDLE;
            ref_row_nxt      = '0;
            ref_col_nxt      = '0;
            ref_ori_nxt      = '0;
            stall_cnt_nxt    = '0;
            out_of_map_nxt   = 1'b0;
            illegal_move_nxt = 1'b0;
            stall_nxt        = 1'b0;
            error_code_nxt   = EC_NONE;
            step_count_nxt   = '0;
        end else if (sample) begin
            case (state)
                S_IDLE: begin
                    if (oom) begin
                        out_of_map_nxt = 1'b1;
                        error_code_nxt = EC_MAP;
                        state_nxt      = S_HALT;
                    end else begin
                        ref_row_nxt   = robot_row;
                        ref_col_nxt   = robot_column;
                        ref_ori_nxt   = robot_orientation;
                        stall_cnt_nxt = '0;
                        state_nxt     = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (oom)       out_of_map_nxt   = 1'b1;
                    if (!legal)    illegal_move_nxt = 1'b1;
                    if (stall_hit) stall_nxt        = 1'b1;

                    if (oom)            error_code_nxt = EC_MAP;
                    else if (!legal)    error_code_nxt = EC_MOVE;
                    else if (stall_hit) error_code_nxt = EC_STALL;

                    if (oom || !legal || stall_hit) state_nxt = S_HALT;

                    // A sample off the map is not a trustworthy position, so
                    // it leaves reference, step and stall tracking untouched.
                    if (!oom) begin
                        ref_row_nxt   = robot_row;
                        ref_col_nxt   = robot_column;
                        ref_ori_nxt   = robot_orientation;
                        stall_cnt_nxt = same_all ? stall_inc : '0;
                        if (!same_cell && (step_count != '1))
                            step_count_nxt = step_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_robot_monitor.sv
// tb_robot_monitor
//   Directed vectors against two monitor instances sharing one input stream:
//   dut (heading not enforced) and dut_h (heading enforced), both with a
//   stall limit of 4. Inputs change on the falling edge; outputs are read on
//   the falling edge after the capturing rising edge.

module tb_robot_monitor;

    localparam int POS_W = 6;
    localparam int CNT_W = 16;

    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] E = 2'b10;
    localparam logic [1:0] W = 2'b11;

    logic             clock;
    logic             reset;
    logic             sample;
    logic [POS_W-1:0] robot_row;
    logic [POS_W-1:0] robot_column;
    logic [1:0]       robot_orientation;
    logic             clear;

    logic             out_of_map,   out_of_map_h;
    logic             illegal_move, illegal_move_h;
    logic             stall,        stall_h;
    logic [1:0]       error_code,   error_code_h;
    logic [CNT_W-1:0] step_count,   step_count_h;
    logic             halted,       halted_h;

    int n_cmp;
    int n_err;

    robot_monitor #(
        .ROWS(10), .COLS(20), .POS_W(POS_W), .STALL_LIMIT(4),
        .CNT_W(CNT_W), .STRICT_HEADING(0)
    ) dut (
        .clock(clock), .reset(reset), .sample(sample),
        .robot_row(robot_row), .robot_column(robot_column),
        .robot_orientation(robot_orientation), .clear(clear),
        .out_of_map(out_of_map), .illegal_move(illegal_move), .stall(stall),
        .error_code(error_code), .step_count(step_count), .halted(halted)
    );

    robot_monitor #(
        .ROWS(10), .COLS(20), .POS_W(POS_W), .STALL_LIMIT(4),
        .CNT_W(CNT_W), .STRICT_HEADING(1)
    ) dut_h (
        .clock(clock), .reset(reset), .sample(sample),
        .robot_row(robot_row), .robot_column(robot_column),
        .robot_orientation(robot_orientation), .clear(clear),
        .out_of_map(out_of_map_h), .illegal_move(illegal_move_h), .stall(stall_h),
        .error_code(error_code_h), .step_count(step_count_h), .halted(halted_h)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int r, input int c, input logic [1:0] o);
        @(negedge clock);
        robot_row         = POS_W'(r);
        robot_column      = POS_W'(c);
        robot_orientation = o;
        sample            = 1'b1;
        @(negedge clock);
        sample            = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic oom, input logic ill,
                           input logic stl, input logic [1:0] ec,
                           input int steps, input logic hlt);
        chk({tag, ".oom"},   32'(out_of_map),   32'(oom));
        chk({tag, ".ill"},   32'(illegal_move), 32'(ill));
        chk({tag, ".stall"}, 32'(stall),        32'(stl));
        chk({tag, ".ec"},    32'(error_code),   32'(ec));
        chk({tag, ".steps"}, 32'(step_count),   32'(steps));
        chk({tag, ".halt"},  32'(halted),       32'(hlt));
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        reset             = 1'b1;
        sample            = 1'b0;
        clear             = 1'b0;
        robot_row         = '0;
        robot_column      = '0;
        robot_orientation = N;
        repeat (3) @(negedge clock);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0);
        reset = 1'b0;

        // straight run east
        put(1, 1, E);
        put(1, 2, E);
        put(1, 3, E);
        chk_all("run", 1'b0, 1'b0, 1'b0, 2'b00, 2, 1'b0);
        chk("run.h.ill", 32'(illegal_move_h), 32'd0);
        repeat (3) @(negedge clock);
        chk("idle_hold.steps", 32'(step_count), 32'd2);

        // leaving the map from (5,5)
        do_clear();
        put(5, 5, N);
        put(0, 5, N);
        chk("oom.oom",  32'(out_of_map), 32'd1);
        chk("oom.ec",   32'(error_code), 32'd1);
        chk("oom.halt", 32'(halted),     32'd1);
        put(5, 6, E);
        chk("oom.after.steps", 32'(step_count), 32'd0);
        chk("oom.after.ec",    32'(error_code), 32'd1);

        // clear and sample together while halted: clear wins, sample dropped
        @(negedge clock);
        clear             = 1'b1;
        sample            = 1'b1;
        robot_row         = POS_W'(2);
        robot_column      = POS_W'(2);
        robot_orientation = N;
        @(negedge clock);
        clear  = 1'b0;
        sample = 1'b0;
        chk_all("clr_smp", 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0);
        put(7, 7, N);
        chk("clr_smp.idle_ref.ill",  32'(illegal_move), 32'd0);
        chk("clr_smp.idle_ref.halt", 32'(halted),       32'd0);

        // diagonal move
        do_clear();
        put(3, 3, N);
        put(4, 4, S);
        chk("diag.ill",  32'(illegal_move), 32'd1);
        chk("diag.ec",   32'(error_code),   32'd2);
        chk("diag.halt", 32'(halted),       32'd1);
        chk("diag.oom",  32'(out_of_map),   32'd0);

        // move south while facing north
        do_clear();
        put(3, 3, N);
        put(4, 3, N);
        chk("head.h.ill",   32'(illegal_move_h), 32'd1);
        chk("head.h.ec",    32'(error_code_h),   32'd2);
        chk("head.h.halt",  32'(halted_h),       32'd1);
        chk("head.ill",     32'(illegal_move),   32'd0);
        chk("head.steps",   32'(step_count),     32'd1);
        chk("head.halt",    32'(halted),         32'd0);

        // five identical samples trip the stall
        do_clear();
        for (int i = 0; i < 4; i++) put(2, 2, W);
        chk("stall4.stall", 32'(stall),  32'd0);
        chk("stall4.halt",  32'(halted), 32'd0);
        put(2, 2, W);
        chk_all("stall5", 1'b0, 1'b0, 1'b1, 2'b11, 0, 1'b1);
        chk("stall5.h.stall", 32'(stall_h), 32'd1);

        // a turn in place restarts the stall count
        do_clear();
        for (int i = 0; i < 3; i++) put(2, 2, W);
        for (int i = 0; i < 4; i++) put(2, 2, N);
        chk_all("turn", 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0);
        put(2, 2, N);
        chk("turn.late.stall", 32'(stall),      32'd1);
        chk("turn.late.ec",    32'(error_code), 32'd3);

        // off map and too far in one sample: both flags, map code wins
        do_clear();
        put(1, 1, N);
        put(0, 3, N);
        chk("both.oom", 32'(out_of_map),   32'd1);
        chk("both.ill", 32'(illegal_move), 32'd1);
        chk("both.ec",  32'(error_code),   32'd1);

        // map edges
        do_clear();
        put(10, 20, S);
        chk("edge.in.oom",  32'(out_of_map), 32'd0);
        chk("edge.in.halt", 32'(halted),     32'd0);
        put(11, 20, S);
        chk("edge.out.oom", 32'(out_of_map),   32'd1);
        chk("edge.out.ill", 32'(illegal_move), 32'd0);
        chk("edge.out.h.ill", 32'(illegal_move_h), 32'd0);
        do_clear();
        put(5, 20, E);
        put(5, 21, E);
        chk("edge.col.oom", 32'(out_of_map), 32'd1);
        do_clear();
        put(1, 1, W);
        put(1, 0, W);
        chk("edge.col0.oom", 32'(out_of_map), 32'd1);

        // async reset in the middle of tracking
        do_clear();
        put(4, 4, N);
        put(4, 5, E);
        chk("prerst.steps", 32'(step_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst.steps", 32'(step_count), 32'd0);
        chk("async_rst.halt",  32'(halted),     32'd0);
        @(negedge clock);
        reset = 1'b0;
        put(8, 8, N);
        chk("post_rst.ill",  32'(illegal_move), 32'd0);
        chk("post_rst.halt", 32'(halted),       32'd0);
        put(8, 9, E);
        chk("post_rst.steps", 32'(step_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
